wifi_tx_arbiter: RTL and testbench

WIFI_TX_ARBITER -- requirements
Module: wifi_tx_arbiter

---
 rtl/wifi_pkg.sv | 37 +++
 rtl/wifi_tx_arbiter_if.sv | 48 ++++
 rtl/sync_2ff.sv | 34 +++
 rtl/wifi_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_wifi_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wifi_pkg.sv
// ============================================================================
// Module   : wifi_pkg
// Brief    : Shared constants, state encoding and arbitration helper for the
//            WiFi UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wifi_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 50000;
    localparam int NUM_REQ         = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One-hot winner; ptr=0 favours requester 0, ptr=1 favours requester 1.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic ptr,
                                                    input logic [NUM_REQ-1:0] req);
        logic [NUM_REQ-1:0] win;
        win = '0;
        if (ptr) begin
            if (req[1])      win = 2'b10;
            else if (req[0]) win = 2'b01;
        end else begin
            if (req[0])      win = 2'b01;
            else if (req[1]) win = 2'b10;
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wifi_tx_arbiter_if.sv
// ============================================================================
// Module   : wifi_tx_arbiter_if
// Brief    : Requester and UART handshake bundle of the WiFi TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wifi_tx_arbiter_if
    import wifi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic               req0_valid;
    logic [DATA_W-1:0]  req0_data;
    logic               req0_last;
    logic               req0_ready;
    logic               req1_valid;
    logic [DATA_W-1:0]  req1_data;
    logic               req1_last;
    logic               req1_ready;
    logic               uart_tx_valid;
    logic [DATA_W-1:0]  uart_tx_data;
    logic               uart_tx_ready;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output uart_tx_ready,
        input  req0_ready, req1_ready,
        input  uart_tx_valid, uart_tx_data,
        input  grant, busy, timeout_err
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  uart_tx_ready,
        output req0_ready, req1_ready,
        output uart_tx_valid, uart_tx_data,
        output grant, busy, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : 1-bit two-flop synchroniser with configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/wifi_tx_arbiter.sv
// ============================================================================
// Module   : wifi_tx_arbiter
// Brief    : Two-requester round-robin packet arbiter feeding a WiFi UART TX,
//            with CTS gating and stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wifi_tx_arbiter
    import wifi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire logic   clk_clk,
    input  wire logic   reset_reset,
    input  wire logic   wifi_cts_n,
    wifi_tx_arbiter_if.slave bus
);

    localparam int                CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  C_STALL_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic                 r_ptr;
    logic                 w_ptr_nxt;
    logic [CNT_W-1:0]     r_stall;
    logic [CNT_W-1:0]     w_stall_nxt;
    logic [NUM_REQ-1:0]   r_block;
    logic [NUM_REQ-1:0]   w_block_nxt;

    logic                 w_cts_n_sync;
    logic                 w_cts_ok;
    logic [NUM_REQ-1:0]   w_valid;
    logic [NUM_REQ-1:0]   w_req;
    logic                 w_sel;
    logic                 w_g_valid;
    logic                 w_g_last;
    logic [DATA_W-1:0]    w_g_data;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_tx_valid;
    logic [DATA_W-1:0]    w_tx_data;
    logic [NUM_REQ-1:0]   w_ready;

    // Synchronise the raw active-low CTS; reset holds it deasserted.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_cts_sync (
        .clk (clk_clk),
        .rst (reset_reset),
        .d   (wifi_cts_n),
        .q   (w_cts_n_sync)
    );

    assign w_cts_ok = ~w_cts_n_sync;
    assign w_valid  = {bus.req1_valid, bus.req0_valid};
    // A requester whose packet was aborted must drop valid before it competes again.
    assign w_req    = w_valid & ~r_block;

    assign w_sel     = r_grant[1];
    assign w_g_valid = w_sel ? bus.req1_valid : bus.req0_valid;
    assign w_g_last  = w_sel ? bus.req1_last  : bus.req0_last;
    assign w_g_data  = w_sel ? bus.req1_data  : bus.req0_data;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= 1'b0;
            r_stall <= '0;
            r_block <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_stall <= w_stall_nxt;
            r_block <= w_block_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_stall_nxt = r_stall;
        w_block_nxt = r_block & w_valid;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_tx_valid  = 1'b0;
        w_tx_data   = '0;
        w_ready     = '0;

        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                if (|w_req) begin
                    w_state_nxt = SEND;
                    w_grant_nxt = rr_pick(r_ptr, w_req);
                    w_stall_nxt = '0;
                end
            end
            SEND: begin
                w_tx_valid       = w_g_valid & w_cts_ok;
                w_tx_data        = w_g_data;
                w_ready[w_sel]   = bus.uart_tx_ready & w_cts_ok;
                w_accept         = w_g_valid & bus.uart_tx_ready & w_cts_ok;
                if (w_accept && w_g_last) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = ~w_sel;
                    w_stall_nxt = '0;
                end else if (!w_accept && (r_stall == C_STALL_MAX)) begin
                    w_timeout          = 1'b1;
                    w_state_nxt        = IDLE;
                    w_grant_nxt        = '0;
                    w_ptr_nxt          = ~w_sel;
                    w_stall_nxt        = '0;
                    w_block_nxt[w_sel] = 1'b1;
                end else if (w_accept) begin
                    w_stall_nxt = '0;
                end else if (r_stall != C_STALL_MAX) begin
                    w_stall_nxt = r_stall + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign bus.uart_tx_valid = w_tx_valid;
    assign bus.uart_tx_data  = w_tx_data;
    assign bus.req0_ready    = w_ready[0];
    assign bus.req1_ready    = w_ready[1];
    assign bus.grant         = r_grant;
    assign bus.busy          = (r_state == SEND);
    assign bus.timeout_err   = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_wifi_tx_arbiter.sv
// ============================================================================
// Module   : tb_wifi_tx_arbiter
// Brief    : Self-checking bench for wifi_tx_arbiter (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wifi_tx_arbiter;

    logic clk;
    logic rst;
    logic cts_n;

    wifi_tx_arbiter_if #(.DATA_W(8)) bus ();

    wifi_tx_arbiter #(
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .wifi_cts_n  (cts_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       rdy;
        logic [1:0] e_grant;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_r0;
        logic       e_r1;
    } vec_t;

    vec_t       vecs[19];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] pkt0[8];
    logic [7:0] pkt1[8];
    int         len0, lim0, idx0, len1, lim1, idx1;
    logic [7:0] rx[$];
    logic [1:0] grant_hist[40];
    logic       txv_hist[40];
    logic       terr_hist[40];
    int         terr_cnt;
    int         k_hi;

    function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0,
                                logic v1, logic [7:0] d1, logic l1, logic rdy,
                                logic [1:0] g, logic txv, logic [7:0] txd,
                                logic r0, logic r1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
        v.e_grant = g; v.e_txv = txv; v.e_txd = txd; v.e_r0 = r0; v.e_r1 = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        bus.req0_valid = (idx0 < lim0);
        bus.req0_data  = (idx0 < 8) ? pkt0[idx0] : 8'h00;
        bus.req0_last  = (idx0 == len0 - 1);
        bus.req1_valid = (idx1 < lim1);
        bus.req1_data  = (idx1 < 8) ? pkt1[idx1] : 8'h00;
        bus.req1_last  = (idx1 == len1 - 1);
    endtask

    // Called mid-cycle: records UART transfers and advances each source on its ready.
    task automatic sample();
        if (bus.uart_tx_valid && bus.uart_tx_ready) rx.push_back(bus.uart_tx_data);
        if (bus.req0_valid && bus.req0_ready) idx0++;
        if (bus.req1_valid && bus.req1_ready) idx1++;
        if (bus.timeout_err) terr_cnt++;
    endtask

    initial begin
        // Contention: A packet then B packet with one idle cycle between.
        vecs[0]  = mk(1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 8'hA0, 0, 1, 8'hB0, 0, 0, 2'b01, 1, 8'hA0, 0, 0);
        vecs[2]  = mk(1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA0, 1, 0);
        vecs[3]  = mk(1, 8'hA1, 0, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA1, 1, 0);
        vecs[4]  = mk(1, 8'hA2, 1, 1, 8'hB0, 0, 1, 2'b01, 1, 8'hA2, 1, 0);
        vecs[5]  = mk(0, 8'h00, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[6]  = mk(0, 8'h00, 0, 1, 8'hB0, 0, 1, 2'b10, 1, 8'hB0, 0, 1);
        vecs[7]  = mk(0, 8'h00, 0, 1, 8'hB1, 0, 1, 2'b10, 1, 8'hB1, 0, 1);
        vecs[8]  = mk(0, 8'h00, 0, 1, 8'hB2, 1, 1, 2'b10, 1, 8'hB2, 0, 1);
        vecs[9]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);
        // Fairness: both always requesting single-byte packets.
        vecs[10] = mk(1, 8'hC0, 1, 1, 8'hD0, 1, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[11] = mk(1, 8'hC0, 1, 1, 8'hD0, 1, 1, 2'b01, 1, 8'hC0, 1, 0);
        vecs[12] = mk(1, 8'hC1, 1, 1, 8'hD0, 1, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[13] = mk(1, 8'hC1, 1, 1, 8'hD0, 1, 1, 2'b10, 1, 8'hD0, 0, 1);
        vecs[14] = mk(1, 8'hC1, 1, 1, 8'hD1, 1, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[15] = mk(1, 8'hC1, 1, 1, 8'hD1, 1, 1, 2'b01, 1, 8'hC1, 1, 0);
        vecs[16] = mk(1, 8'hC2, 1, 1, 8'hD1, 1, 1, 2'b00, 0, 8'h00, 0, 0);
        vecs[17] = mk(1, 8'hC2, 1, 1, 8'hD1, 1, 1, 2'b10, 1, 8'hD1, 0, 1);
        vecs[18] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 8'h00, 0, 0);

        rst = 1'b1; cts_n = 1'b1; bus.uart_tx_ready = 1'b1;
        len0 = 0; lim0 = 0; idx0 = 0; len1 = 0; lim1 = 0; idx1 = 0; terr_cnt = 0;
        drive_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset grant", 32'(bus.grant), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        chk("reset ready0", 32'(bus.req0_ready), 32'h0);
        chk("reset ready1", 32'(bus.req1_ready), 32'h0);
        chk("reset timeout_err", 32'(bus.timeout_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; cts_n = 1'b0;
        repeat (3) @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            bus.req0_valid = vecs[i].v0; bus.req0_data = vecs[i].d0; bus.req0_last = vecs[i].l0;
            bus.req1_valid = vecs[i].v1; bus.req1_data = vecs[i].d1; bus.req1_last = vecs[i].l1;
            bus.uart_tx_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d grant", i), 32'(bus.grant), 32'(vecs[i].e_grant));
            chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_grant != 2'b00));
            chk($sformatf("row%0d tx_valid", i), 32'(bus.uart_tx_valid), 32'(vecs[i].e_txv));
            if (vecs[i].e_txv)
                chk($sformatf("row%0d tx_data", i), 32'(bus.uart_tx_data), 32'(vecs[i].e_txd));
            chk($sformatf("row%0d ready0", i), 32'(bus.req0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("row%0d ready1", i), 32'(bus.req1_ready), 32'(vecs[i].e_r1));
            @(posedge clk); #1;
        end
        bus.uart_tx_ready = 1'b1;

        // CTS gating: 4-byte packet, cts_n high after first byte for 6 cycles.
        pkt0[0] = 8'hE0; pkt0[1] = 8'hE1; pkt0[2] = 8'hE2; pkt0[3] = 8'hE3;
        len0 = 4; lim0 = 4; idx0 = 0; len1 = 0; lim1 = 0; idx1 = 0;
        rx.delete(); terr_cnt = 0; k_hi = -1;
        drive_src();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            txv_hist[n] = bus.uart_tx_valid;
            grant_hist[n] = bus.grant;
            sample();
            @(posedge clk); #1;
            if (k_hi < 0 && rx.size() == 1) begin k_hi = n + 1; cts_n = 1'b1; end
            if (k_hi >= 0 && n + 1 == k_hi + 6) cts_n = 1'b0;
            drive_src();
        end
        if (k_hi < 0 || k_hi > 10) begin
            checks++; errors++;
            $display("FAIL cts first byte: got k_hi=%0d expected 2", k_hi);
        end else begin
            chk("cts k_hi", 32'(k_hi), 32'd2);
            chk("cts still valid +1", 32'(txv_hist[k_hi+1]), 32'h1);
            chk("cts gated +2", 32'(txv_hist[k_hi+2]), 32'h0);
            chk("cts grant held", 32'(grant_hist[k_hi+4]), 32'h1);
            chk("cts gated after release +1", 32'(txv_hist[k_hi+7]), 32'h0);
            chk("cts resumed +2", 32'(txv_hist[k_hi+8]), 32'h1);
        end
        chk("cts rx count", 32'(rx.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx.size(); i++)
            chk($sformatf("cts rx[%0d]", i), 32'(rx[i]), 32'(8'hE0 + 8'(i)));
        chk("cts no timeout", 32'(terr_cnt), 32'd0);

        // Timeout: req0 sends 1 of 3 bytes then stalls; req1 waits.
        pkt0[0] = 8'h70; pkt0[1] = 8'h71; pkt0[2] = 8'h72; pkt1[0] = 8'hF0;
        len0 = 3; lim0 = 1; idx0 = 0; len1 = 1; lim1 = 0; idx1 = 0;
        rx.delete(); terr_cnt = 0;
        drive_src();
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            grant_hist[n] = bus.grant;
            terr_hist[n] = bus.timeout_err;
            sample();
            @(posedge clk); #1;
            if (n == 1) lim1 = 1;
            drive_src();
        end
        chk("to grant first", 32'(grant_hist[1]), 32'h1);
        chk("to grant held idle valid", 32'(grant_hist[10]), 32'h1);
        chk("to no early pulse", 32'(terr_hist[16]), 32'h0);
        chk("to pulse", 32'(terr_hist[17]), 32'h1);
        chk("to pulse one cycle", 32'(terr_hist[18]), 32'h0);
        chk("to pulse count", 32'(terr_cnt), 32'd1);
        chk("to idle after", 32'(grant_hist[18]), 32'h0);
        chk("to req1 granted", 32'(grant_hist[19]), 32'h2);
        chk("to rx count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("to rx[0]", 32'(rx[0]), 32'h70);
            chk("to rx[1]", 32'(rx[1]), 32'hF0);
        end

        // Reset mid-packet: req0 1-byte packet, then req1 5-byte packet interrupted.
        pkt0[0] = 8'h60;
        for (int i = 0; i < 5; i++) pkt1[i] = 8'h80 + 8'(i);
        len0 = 1; lim0 = 1; idx0 = 0; len1 = 5; lim1 = 5; idx1 = 0;
        rx.delete();
        drive_src();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            grant_hist[n] = bus.grant;
            sample();
            if (n < 4) begin
                @(posedge clk); #1;
                drive_src();
            end
        end
        chk("rst pre grant0", 32'(grant_hist[1]), 32'h1);
        chk("rst pre grant1", 32'(grant_hist[3]), 32'h2);
        chk("rst pre owner", 32'(grant_hist[4]), 32'h2);
        chk("rst pre rx count", 32'(rx.size()), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("rst async grant", 32'(bus.grant), 32'h0);
        chk("rst async busy", 32'(bus.busy), 32'h0);
        chk("rst async tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pkt0[0] = 8'h90; pkt1[0] = 8'h91;
        len0 = 1; lim0 = 1; idx0 = 0; len1 = 1; lim1 = 1; idx1 = 0;
        rx.delete();
        drive_src();
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            grant_hist[n] = bus.grant;
            txv_hist[n] = bus.uart_tx_valid;
            sample();
            @(posedge clk); #1;
            drive_src();
        end
        chk("rst post idle", 32'(grant_hist[0]), 32'h0);
        chk("rst post req0 first", 32'(grant_hist[1]), 32'h1);
        chk("rst post cts syncing", 32'(txv_hist[1]), 32'h0);
        chk("rst post cts ok", 32'(txv_hist[2]), 32'h1);
        chk("rst post req1 next", 32'(grant_hist[4]), 32'h2);
        chk("rst post rx count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("rst post rx[0]", 32'(rx[0]), 32'h90);
            chk("rst post rx[1]", 32'(rx[1]), 32'h91);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
